pooling_stream_ctrl: RTL
========================

Name: pooling_stream_ctrl

Overview:
- Streaming sequencer for one max-pooling layer channel. Accepts one input_size x input_size feature map as a raster-order pixel stream.
- Buffers one strip of pooling_size rows, then presents each pooling_size x pooling_size window to a max_pool instance.
- Emits one pooled value per window over a valid/ready stream.
- Sits between the convolution output stream and the next layer, replacing the fully parallel whole-map pooling array when area matters.

Parameters:
- input_size, 4, feature map width/height in pixels (>=1).
- pooling_size, 2, window edge and stride (1..input_size).
- Derived constant out_size = input_size/pooling_size (floor). Derived constant out_count = out_size*out_size.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a frame when idle.
- busy  out  1  high from the accepted start until the cycle done pulses, inclusive.
- done  out  1  single-cycle pulse after the last pixel and last output of the frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  controller can accept a pixel this cycle.
- in_data  in  32  input pixel, signed two's complement.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  pooled maximum, signed.
- out_index  out  max(1,$clog2(out_count))  raster index of the result, row*out_size+col.

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE; busy, done, in_ready and out_valid = 0; out_data = 0; out_index = 0; all counters = 0. The strip buffer is not cleared; its contents are don't-care.
- Transfers: an input transfer is in_valid&&in_ready at a rising edge; an output transfer is out_valid&&out_ready. in_ready must not depend combinationally on in_valid; out_valid must not depend on out_ready.
- Pixel counters: row r (0..input_size-1), column c (0..input_size-1), strip row sr (0..pooling_size-1).
- Output counters: output column oc (0..out_size-1), output row orow.
- IDLE:
  - in_ready=0, out_valid=0.
  - start -> FILL, busy=1, all counters cleared.
  - start while busy is ignored.
- FILL:
  - in_ready=1.
  - Each input transfer writes the pixel to strip buffer [sr][c] when c < out_size*pooling_size. Pixels in trailing columns (c >= out_size*pooling_size) are accepted and discarded.
  - The transfer with c=input_size-1 and sr=pooling_size-1 -> LOAD with oc=0.
- LOAD (1 cycle):
  - in_ready=0.
  - Window oc is buffer [0..pooling_size-1][oc*pooling_size .. oc*pooling_size+pooling_size-1], packed k*pooling_size+l.
  - The window is fed to max_pool; its result is registered into out_data, and out_index is set to orow*out_size+oc. -> EMIT.
- EMIT:
  - out_valid=1; out_data and out_index are held stable until the output transfer.
  - On the transfer:
    - If oc<out_size-1: oc++ -> LOAD.
    - Else if orow<out_size-1: orow++, oc=0 -> FILL.
    - Else if out_size*pooling_size<input_size: -> SKIP.
    - Else: -> FINISH.
- SKIP:
  - in_ready=1; accepts and discards the remaining (input_size mod pooling_size) rows.
  - The transfer of pixel (input_size-1, input_size-1) -> FINISH.
- FINISH (1 cycle): done=1, busy stays 1 this cycle -> IDLE (busy=0 next cycle).
- Throughput: minimum 2 cycles per output. No input is accepted during LOAD/EMIT; upstream stalls.
- Comparison is signed. On ties any equal value is correct; out_data is identical either way.
- pooling_size=1: every pixel is a window; the output stream equals the input stream in order.
- pooling_size=input_size: one output per frame.
- Inputs arriving while in IDLE are not accepted, since in_ready=0.

Decomposition:
- Shared package holds:
  - Pixel typedef: signed 32-bit word.
  - State enum: IDLE, FILL, LOAD, EMIT, SKIP, FINISH.
  - Helper function computing out_index width (max(1,$clog2(n))).
- Sub-module: existing max_pool, parameterised window_size=pooling_size, instantiated once. This block is its sequencer.
- Strip buffer is local register array of pooling_size*(out_size*pooling_size) words.

Test Plan:
- 4x4 map, pooling_size 2, pixels 0..15 raster, out_ready=1 -> out_data 5,7,13,15 with out_index 0..3; done one cycle after the last output transfer.
- Same map, out_ready toggling 1-in-3 and in_valid random -> identical values/indices; out_data/out_index stable while out_valid && !out_ready; in_ready=0 throughout LOAD/EMIT.
- 5x5 map, pooling_size 2, pixels 0..24 -> exactly 4 outputs 6,8,16,18; column 4 and row 4 consumed (all 25 pixels accepted) then done.
- 4x4 all negative (-16..-1), pooling_size 4 -> single output -1 at index 0; pooling_size 1 -> outputs equal inputs in order.
- Reset asserted during EMIT of the second output -> all outputs 0 and state IDLE asynchronously. The next start with a fresh frame yields correct results from index 0.
- start pulsed again mid-frame -> ignored; frame completes normally with exactly one done pulse.

Source files
------------

// File: rtl/pooling_stream_ctrl_pkg.sv
// Shared definitions for the pooling stream controller slice.
// Contents:
//   pixel_t   - signed 32-bit feature-map word
//   state_t   - sequencer states
//   idx_width - width needed to index n items, never less than 1 bit
package pooling_stream_ctrl_pkg;

  typedef logic signed [31:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    LOAD   = 3'd2,
    EMIT   = 3'd3,
    SKIP   = 3'd4,
    FINISH = 3'd5
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pooling_stream_ctrl_if.sv
// Handshake bundle between the pooling controller and its environment.
// Signals: start/busy/done frame control, in_* pixel stream, out_* result
// stream. IDX_W is the width of out_index.
// Modports: slave = the controller, master = the driving environment.
interface pooling_stream_ctrl_if #(
  parameter int IDX_W = 2
) ();
  import pooling_stream_ctrl_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  pixel_t           in_data;
  logic             out_valid;
  logic             out_ready;
  pixel_t           out_data;
  logic [IDX_W-1:0] out_index;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  busy, done, in_ready, out_valid, out_data, out_index
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output busy, done, in_ready, out_valid, out_data, out_index
  );

endinterface

// File: rtl/pooling_stream_ctrl_max_pool.sv
// max_pool: combinational signed maximum over one square window.
// Ports:
//   i_window - WINDOW_SIZE*WINDOW_SIZE pixels, packed row-major (k*W+l)
//   o_max    - largest pixel, signed comparison
module max_pool
  import pooling_stream_ctrl_pkg::*;
#(
  parameter int WINDOW_SIZE = 2
) (
  input  pixel_t i_window [WINDOW_SIZE*WINDOW_SIZE],
  output pixel_t o_max
);

  localparam int N = WINDOW_SIZE * WINDOW_SIZE;

  pixel_t w_max;

  // Linear scan keeping the running signed maximum.
  always_comb begin
    w_max = i_window[0];
    for (int i = 1; i < N; i++) begin
      if (i_window[i] > w_max) begin
        w_max = i_window[i];
      end else begin
        w_max = w_max;
      end
    end
  end

  assign o_max = w_max;

endmodule

// File: rtl/pooling_stream_ctrl.sv
// pooling_stream_ctrl: streaming sequencer for one max-pooling channel.
// Collects POOLING_SIZE rows of a raster pixel stream into a strip buffer,
// then feeds each window of the strip to max_pool and emits one result per
// window. Trailing columns/rows that do not fill a window are consumed and
// dropped.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - slave side of pooling_stream_ctrl_if (frame control, pixel in,
//           pooled result out with raster index)
module pooling_stream_ctrl
  import pooling_stream_ctrl_pkg::*;
#(
  parameter int INPUT_SIZE   = 4,
  parameter int POOLING_SIZE = 2
) (
  input logic                  clk,
  input logic                  reset,
  pooling_stream_ctrl_if.slave bus
);

  localparam int OUT_SIZE  = INPUT_SIZE / POOLING_SIZE;
  localparam int OUT_COUNT = OUT_SIZE * OUT_SIZE;
  localparam int USED_COLS = OUT_SIZE * POOLING_SIZE;
  localparam int WIN       = POOLING_SIZE * POOLING_SIZE;
  localparam int IDX_W     = idx_width(OUT_COUNT);
  localparam int CW        = idx_width(INPUT_SIZE + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_row, r_col, r_sr, r_oc, r_orow;
  pixel_t           r_out_data;
  logic [IDX_W-1:0] r_out_index;
  pixel_t           r_buf [POOLING_SIZE][USED_COLS];
  pixel_t           w_window [WIN];
  pixel_t           w_max;
  logic             w_in_ready, w_out_valid, w_busy, w_done;
  logic             w_in_xfer, w_last_col;

  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_last_col = (r_col == CW'(INPUT_SIZE - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = bus.start ? FILL : IDLE;
      FILL:   w_next = (w_in_xfer && w_last_col && r_sr == CW'(POOLING_SIZE - 1)) ? LOAD : FILL;
      LOAD:   w_next = EMIT;
      EMIT: begin
        if (!bus.out_ready) begin
          w_next = EMIT;
        end else if (r_oc < CW'(OUT_SIZE - 1)) begin
          w_next = LOAD;
        end else if (r_orow < CW'(OUT_SIZE - 1)) begin
          w_next = FILL;
        end else if (USED_COLS < INPUT_SIZE) begin
          w_next = SKIP;
        end else begin
          w_next = FINISH;
        end
      end
      SKIP:   w_next = (w_in_xfer && w_last_col && r_row == CW'(INPUT_SIZE - 1)) ? FINISH : SKIP;
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE:   w_busy = 1'b0;
      FILL:   begin w_in_ready = 1'b1; w_busy = 1'b1; end
      LOAD:   w_busy = 1'b1;
      EMIT:   begin w_out_valid = 1'b1; w_busy = 1'b1; end
      SKIP:   begin w_in_ready = 1'b1; w_busy = 1'b1; end
      FINISH: begin w_done = 1'b1; w_busy = 1'b1; end
      default: w_busy = 1'b0;
    endcase
  end

  // Pixel/output counters and the registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row       <= CW'(0);
      r_col       <= CW'(0);
      r_sr        <= CW'(0);
      r_oc        <= CW'(0);
      r_orow      <= CW'(0);
      r_out_data  <= 32'sd0;
      r_out_index <= IDX_W'(0);
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_row  <= CW'(0);
            r_col  <= CW'(0);
            r_sr   <= CW'(0);
            r_oc   <= CW'(0);
            r_orow <= CW'(0);
          end
        end
        FILL, SKIP: begin
          if (w_in_xfer) begin
            if (w_last_col) begin
              r_col <= CW'(0);
              r_row <= (r_row == CW'(INPUT_SIZE - 1)) ? CW'(0) : r_row + CW'(1);
              r_sr  <= (r_sr == CW'(POOLING_SIZE - 1)) ? CW'(0) : r_sr + CW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        LOAD: begin
          r_out_data  <= w_max;
          r_out_index <= IDX_W'(int'(r_orow) * OUT_SIZE + int'(r_oc));
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (r_oc < CW'(OUT_SIZE - 1)) begin
              r_oc <= r_oc + CW'(1);
            end else begin
              r_oc <= CW'(0);
              if (r_orow < CW'(OUT_SIZE - 1)) begin
                r_orow <= r_orow + CW'(1);
              end
            end
          end
        end
        default: r_oc <= r_oc;
      endcase
    end
  end

  // Strip buffer capture; its contents carry no meaning after reset, so it
  // has no reset branch. Trailing columns never match a slot and are dropped.
  always_ff @(posedge clk) begin
    if (r_state == FILL && w_in_xfer) begin
      for (int s = 0; s < POOLING_SIZE; s++) begin
        for (int c = 0; c < USED_COLS; c++) begin
          if (r_sr == CW'(s) && r_col == CW'(c)) begin
            r_buf[s][c] <= bus.in_data;
          end
        end
      end
    end
  end

  // Window select for the current output column, packed k*POOLING_SIZE+l.
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      w_window[i] = 32'sd0;
    end
    for (int j = 0; j < OUT_SIZE; j++) begin
      if (r_oc == CW'(j)) begin
        for (int k = 0; k < POOLING_SIZE; k++) begin
          for (int l = 0; l < POOLING_SIZE; l++) begin
            w_window[k*POOLING_SIZE + l] = r_buf[k][j*POOLING_SIZE + l];
          end
        end
      end else begin
        w_window[0] = w_window[0];
      end
    end
  end

  max_pool #(.WINDOW_SIZE(POOLING_SIZE)) u_max_pool (
    .i_window (w_window),
    .o_max    (w_max)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;

endmodule
